// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] BEGIN_ADDR = 32'h1C00_0000;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small flop-based FIFO with synchronous clear and simultaneous push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: credit-limited imem requests, tag/instruction FIFOs, flush drain FSM.
// Optional perf counters under `INST_FETCH_PERF_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_state_t     state;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] occupancy;
  logic             credit_ok;
  logic             req_fire;
  logic             keep_rsp;
  logic             id_pop;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t     rsp_entry;
  fetch_entry_t     id_entry;

  // Credits cover in-flight and buffered entries, so responses never need backpressure.
  assign occupancy      = inflight + buf_cnt;
  assign credit_ok      = occupancy < DEPTH_CNT;
  assign imem_req_valid = credit_ok & ~flush & ~rst;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign pc_en          = req_fire;
  assign imem_req_addr  = pc;

  assign keep_rsp = imem_rsp_valid & (state == RUN) & ~flush;
  assign id_valid = (buf_cnt != '0);
  assign id_pop   = id_valid & id_ready;

  always_comb begin
    rsp_entry      = '0;
    rsp_entry.pc   = tag_head;
    rsp_entry.inst = imem_rsp_data;
  end

  assign id_pc   = id_valid ? id_entry.pc   : '0;
  assign id_inst = id_valid ? id_entry.inst : '0;

  // Tag FIFO occupancy is the in-flight count; it survives flush so stale responses still pop it.
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_rsp_valid),
    .head      (tag_head),
    .count     (inflight)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (keep_rsp),
    .push_data (rsp_entry),
    .pop       (id_pop),
    .head      (id_entry),
    .count     (buf_cnt)
  );

  assign drop_next = inflight - CNT_W'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_next;
      state    <= (drop_next != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && imem_rsp_valid) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
      if (drop_cnt == CNT_W'(1)) state <= RUN;
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_fire)             perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_ready && !id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
